// File: rtl/timer_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | timer_counter : memory-mapped 32-bit down-counting timer, one-shot or     |
// |                 auto-reload periodic, level irq to the HWInt vector.      |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  localparam logic [1:0] C_ADDR_CTRL   = 2'd0;
  localparam logic [1:0] C_ADDR_PRESET = 2'd1;
  localparam logic [1:0] C_ADDR_COUNT  = 2'd2;
  localparam logic [1:0] C_MODE_PERIOD = 2'b01;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_CNT  = 2'd2,
    S_INT  = 2'd3
  } state_t;

  state_t      r_state;
  state_t      w_next;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_irq_flag;

  logic w_en;
  logic w_mode1;
  logic w_load;
  logic w_dec;
  logic w_expire;
  logic w_hw_clr_en;
  logic w_pulse_clr;
  logic w_wr_ctrl;
  logic w_wr_preset;
  logic w_unused_din;

  assign w_en         = r_ctrl[0];
  assign w_mode1      = (r_ctrl[2:1] == C_MODE_PERIOD);
  assign w_wr_ctrl    = we && (addr == C_ADDR_CTRL);
  assign w_wr_preset  = we && (addr == C_ADDR_PRESET);
  assign w_unused_din = ^din[31:4];

  always_comb begin
    w_next      = r_state;
    w_load      = 1'b0;
    w_dec       = 1'b0;
    w_expire    = 1'b0;
    w_hw_clr_en = 1'b0;
    w_pulse_clr = 1'b0;
    case (r_state)
      S_IDLE: if (w_en) w_next = S_LOAD;
      S_LOAD: begin
        w_load = 1'b1;
        w_next = S_CNT;
      end
      S_CNT: begin
        if (!w_en) begin
          w_next = S_IDLE;
        end else if (r_count > 32'd1) begin
          w_dec = 1'b1;
        end else begin
          // COUNT of 0 or 1 both expire here, so PRESET=0 never wraps
          w_expire = 1'b1;
          w_next   = S_INT;
        end
      end
      S_INT: begin
        if (w_mode1) begin
          w_pulse_clr = 1'b1;
          w_next      = w_en ? S_LOAD : S_IDLE;
        end else begin
          w_hw_clr_en = 1'b1;
          w_next      = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  // Software CTRL writes take priority over every hardware update of CTRL/flag
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ctrl     <= 4'd0;
      r_preset   <= 32'd0;
      r_count    <= 32'd0;
      r_irq_flag <= 1'b0;
    end else begin
      if (w_load)        r_count <= r_preset;
      else if (w_dec)    r_count <= r_count - 32'd1;
      else if (w_expire) r_count <= 32'd0;

      if (w_wr_ctrl)        r_ctrl    <= din[3:0];
      else if (w_hw_clr_en) r_ctrl[0] <= 1'b0;

      if (w_wr_ctrl)        r_irq_flag <= 1'b0;
      else if (w_expire)    r_irq_flag <= 1'b1;
      else if (w_pulse_clr) r_irq_flag <= 1'b0;

      if (w_wr_preset) r_preset <= din;
    end
  end

  always_comb begin
    dout = 32'd0;
    case (addr)
      C_ADDR_CTRL:   dout = {28'd0, r_ctrl};
      C_ADDR_PRESET: dout = r_preset;
      C_ADDR_COUNT:  dout = r_count;
      default:       dout = 32'd0;
    endcase
  end

  assign irq = r_irq_flag & r_ctrl[3];

endmodule
`default_nettype wire

// File: tb/tb_timer_counter.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_timer_counter : self-checking bench for timer_counter.                 |
// | Revision 1.0                                                              |
// +--------------------------------------------------------------------------+
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int errors = 0;
  int checks = 0;
  bit chk_on = 1'b0;

  timer_counter dut (
    .clk   (clk),
    .reset (reset),
    .addr  (addr),
    .we    (we),
    .din   (din),
    .dout  (dout),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // Reference model: phase 0 idle, 1 load, 2 counting, 3 expired
  int          m_phase = 0;
  logic [3:0]  m_ctrl = 4'd0;
  logic [31:0] m_preset = 32'd0;
  logic [31:0] m_count = 32'd0;
  bit          m_flag = 1'b0;
  int          n_phase;
  logic [3:0]  n_ctrl;
  logic [31:0] n_preset;
  logic [31:0] n_count;
  bit          n_flag;

  always @(posedge clk) begin
    if (reset) begin
      m_phase = 0; m_ctrl = 4'd0; m_preset = 32'd0; m_count = 32'd0; m_flag = 1'b0;
    end else begin
      n_phase = m_phase; n_ctrl = m_ctrl; n_preset = m_preset;
      n_count = m_count; n_flag = m_flag;
      if (m_phase == 0) begin
        if (m_ctrl[0]) n_phase = 1;
      end else if (m_phase == 1) begin
        n_count = m_preset;
        n_phase = 2;
      end else if (m_phase == 2) begin
        if (!m_ctrl[0]) n_phase = 0;
        else if (m_count > 1) n_count = m_count - 1;
        else begin n_count = 0; n_flag = 1'b1; n_phase = 3; end
      end else begin
        if (m_ctrl[2:1] == 2'b01) begin
          n_flag  = 1'b0;
          n_phase = m_ctrl[0] ? 1 : 0;
        end else begin
          n_ctrl[0] = 1'b0;
          n_phase   = 0;
        end
      end
      if (we && addr == 2'd0) begin n_ctrl = din[3:0]; n_flag = 1'b0; end
      if (we && addr == 2'd1) n_preset = din;
      m_phase = n_phase; m_ctrl = n_ctrl; m_preset = n_preset;
      m_count = n_count; m_flag = n_flag;
    end
  end

  logic [31:0] exp_dout;
  always @(negedge clk) begin
    if (chk_on) begin
      case (addr)
        2'd0:    exp_dout = {28'd0, m_ctrl};
        2'd1:    exp_dout = m_preset;
        2'd2:    exp_dout = m_count;
        default: exp_dout = 32'd0;
      endcase
      checks++;
      if (dout !== exp_dout) begin
        errors++;
        $display("FAIL model_dout t=%0t addr=%0d got=%h want=%h", $time, addr, dout, exp_dout);
      end
      checks++;
      if (irq !== (m_flag & m_ctrl[3])) begin
        errors++;
        $display("FAIL model_irq t=%0t got=%b want=%b", $time, irq, m_flag & m_ctrl[3]);
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got=%h want=%h", name, act, exp);
    end
  endtask

  // Inputs are held across the next rising edge; returns 2ns after it
  task automatic drive(input logic w, input logic [1:0] a, input logic [31:0] d);
    we = w; addr = a; din = d;
    @(posedge clk);
    #2;
  endtask

  task automatic wait_count(input logic [31:0] val, input int limit, input string name);
    bit found = 1'b0;
    for (int i = 0; i < limit && !found; i++) begin
      drive(1'b0, 2'd2, 32'd0);
      if (dout == val) found = 1'b1;
    end
    chk(name, {31'd0, found}, 32'd1);
  endtask

  int pulses;

  initial begin
    reset = 1'b1; we = 1'b0; addr = 2'd0; din = 32'd0;
    @(posedge clk); #2;
    drive(1'b0, 2'd0, 32'd0);
    reset = 1'b0;
    chk_on = 1'b1;

    for (int a = 0; a < 4; a++) begin
      addr = a[1:0]; #1;
      chk($sformatf("reset_dout_a%0d", a), dout, 32'd0);
    end
    chk("reset_irq", {31'd0, irq}, 32'd0);

    // One-shot, PRESET=5
    drive(1'b1, 2'd1, 32'd5);
    drive(1'b1, 2'd0, 32'h9);
    drive(1'b0, 2'd2, 32'd0);
    for (int k = 5; k >= 1; k--) begin
      drive(1'b0, 2'd2, 32'd0);
      chk($sformatf("oneshot_count_%0d", k), dout, k);
    end
    drive(1'b0, 2'd2, 32'd0);
    chk("oneshot_count_0", dout, 32'd0);
    chk("oneshot_irq_set", {31'd0, irq}, 32'd1);
    drive(1'b0, 2'd0, 32'd0);
    chk("oneshot_en_cleared", dout, 32'h8);
    chk("oneshot_irq_held", {31'd0, irq}, 32'd1);
    drive(1'b1, 2'd0, 32'd0);
    chk("oneshot_irq_ack", {31'd0, irq}, 32'd0);

    // Periodic, PRESET=3: five pulses in any 25-cycle window
    drive(1'b1, 2'd1, 32'd3);
    drive(1'b1, 2'd0, 32'hB);
    for (int i = 0; i < 8; i++) drive(1'b0, 2'd2, 32'd0);
    pulses = 0;
    for (int i = 0; i < 25; i++) begin
      drive(1'b0, 2'd2, 32'd0);
      if (irq) pulses++;
    end
    chk("periodic_pulses", pulses, 32'd5);
    drive(1'b1, 2'd0, 32'd0);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd2, 32'd0);

    // Mid-count PRESET rewrite and ignored COUNT write
    drive(1'b1, 2'd1, 32'd10);
    drive(1'b1, 2'd0, 32'hB);
    wait_count(32'd7, 20, "midcount_reach7");
    drive(1'b1, 2'd1, 32'd100);
    addr = 2'd2; #1;
    chk("midcount_preset_no_disturb", dout, 32'd6);
    drive(1'b1, 2'd2, 32'hFFFF);
    chk("count_write_ignored", dout, 32'd5);
    wait_count(32'd100, 20, "midcount_reload100");
    drive(1'b1, 2'd0, 32'd0);

    // Masked expiry, PRESET=2
    drive(1'b1, 2'd1, 32'd2);
    drive(1'b1, 2'd0, 32'h1);
    for (int i = 0; i < 6; i++) drive(1'b0, 2'd0, 32'd0);
    chk("masked_irq", {31'd0, irq}, 32'd0);
    chk("masked_ctrl_en_cleared", dout, 32'd0);
    drive(1'b1, 2'd0, 32'h8);
    chk("unmask_after_clear_irq", {31'd0, irq}, 32'd0);
    drive(1'b1, 2'd0, 32'd0);

    // Reset mid-count at COUNT=40
    drive(1'b1, 2'd1, 32'd50);
    drive(1'b1, 2'd0, 32'h9);
    wait_count(32'd40, 30, "reset_reach40");
    reset = 1'b1;
    drive(1'b0, 2'd2, 32'd0);
    reset = 1'b0;
    for (int a = 0; a < 4; a++) begin
      addr = a[1:0]; #1;
      chk($sformatf("midreset_dout_a%0d", a), dout, 32'd0);
    end
    chk("midreset_irq", {31'd0, irq}, 32'd0);
    drive(1'b0, 2'd2, 32'd0);
    chk("midreset_stays_idle", dout, 32'd0);

    // CTRL write in the same cycle as the INT state (mode 0)
    drive(1'b1, 2'd1, 32'd2);
    drive(1'b1, 2'd0, 32'h9);
    for (int i = 0; i < 4; i++) drive(1'b0, 2'd0, 32'd0);
    chk("simul_irq_before", {31'd0, irq}, 32'd1);
    drive(1'b1, 2'd0, 32'h9);
    chk("simul_ctrl_kept", dout, 32'h9);
    chk("simul_flag_cleared", {31'd0, irq}, 32'd0);
    drive(1'b1, 2'd0, 32'd0);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      logic [1:0]  a;
      logic [31:0] d;
      logic        w;
      a = 2'($urandom_range(0, 3));
      w = ($urandom_range(0, 3) == 0);
      d = $urandom;
      if (a == 2'd1) d = $urandom_range(0, 6);
      if (a == 2'd0) d[0] = ($urandom_range(0, 9) < 7);
      reset = ($urandom_range(0, 99) == 0);
      drive(w, a, d);
    end
    reset = 1'b0;
    drive(1'b0, 2'd0, 32'd0);

    chk_on = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout t=%0t", $time);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
